operand_entry_ctrl: RTL and testbench
=====================================

Name: operand_entry_ctrl

Overview:
- Front-panel sequencer for the signed multiplier.
- Takes the already-synchronized switch bank and two push buttons (enter, clear), debounces the buttons, and turns presses into single-cycle events.
- Steps an FSM that captures operand A, then operand B, starts the multiplier, and holds the display state until the user clears or re-enters.
- Sits between the per-input synchronizers and the multiplier/display datapath.

Parameters:
- WIDTH, 8, operand width in bits (two's complement).
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a button level change. Minimum 2; the bench uses 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sw  input  WIDTH  operand switches, already synchronized upstream.
- btn_enter  input  1  enter button, synchronized but not debounced.
- btn_clear  input  1  clear button, synchronized but not debounced.
- mul_done  input  1  single-cycle pulse from the multiplier: product valid.
- op_a  output  WIDTH  captured operand A, registered.
- op_b  output  WIDTH  captured operand B, registered.
- mul_start  output  1  single-cycle start pulse to the multiplier.
- show_result  output  1  high while the display should show the product.
- state  output  2  current FSM state for the LEDs: 0=IDLE, 1=GOT_A, 2=BUSY, 3=SHOW.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, op_a=0, op_b=0, mul_start=0, show_result=0, debounced levels=0, debounce counters=0, press pulses=0.
- Debounce, independent per button:
  - A counter increments while the raw input differs from the debounced level, and clears to 0 when they match.
  - When the counter reaches DEB_CYCLES-1 while the input still differs, the debounced level toggles and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never changes the level.
- Press pulse: 1 for exactly one cycle, on the cycle after the debounced level rises 0->1. Release generates nothing.
- Latency: a clean raw rise reaches the press pulse DEB_CYCLES+1 cycles later.
- FSM, evaluated on the press pulses:
  - IDLE: enter -> op_a<=sw, go GOT_A.
  - GOT_A: enter -> op_b<=sw, mul_start=1 for the transition cycle only, go BUSY.
  - BUSY: mul_done -> go SHOW. enter is ignored.
  - SHOW: show_result=1. enter -> op_a<=sw, op_b<=0, go GOT_A (a new entry starts directly). mul_done is ignored.
- Clear press in any state -> IDLE, op_a=0, op_b=0, show_result=0, mul_start=0.
- Clear and enter pulses in the same cycle: clear wins, enter is discarded.
- Clear pulse and mul_done in the same cycle while BUSY: clear wins; the late result is never shown.
- mul_done outside BUSY: ignored, no state change.
- show_result is registered: 1 exactly when state==SHOW.
- mul_start is registered: never high for more than 1 cycle, never high outside the GOT_A->BUSY transition.
- op_a and op_b change only on the capture events above; they are stable throughout BUSY and SHOW.
- sw changing in any state has no effect except at a capture event.
- Counter width is clog2(DEB_CYCLES). The counter saturates logic-wise at the toggle point and never wraps.
- Reset asserted mid-operation (e.g. during BUSY) aborts immediately to the reset values. A mul_done arriving after reset release is ignored because state is IDLE.

Decomposition:
- Shared package holds:
  - the state encoding constants ST_IDLE=2'd0, ST_GOT_A=2'd1, ST_BUSY=2'd2, ST_SHOW=2'd3, reused by the display/LED logic;
  - the default DEB_CYCLES value for the board clock.
- One natural sub-module: button_debounce, parameterized by DEB_CYCLES, with ports clk, rst_n, raw, level, press. It is instantiated twice, for enter and clear.
- The FSM and operand registers stay in operand_entry_ctrl.

Test Plan:
- Reset, then hold btn_enter=1 for 10 cycles with DEB_CYCLES=4, sw=8'hF6 -> exactly one press, op_a=8'hF6, state=1. No second capture while held.
- From IDLE, btn_enter glitch high for 3 cycles then low (DEB_CYCLES=4) -> no press, state stays 0, op_a=0.
- Full run: enter with sw=8'h05, enter with sw=8'hFD -> op_a=5, op_b=-3, mul_start high exactly 1 cycle, state=2. Pulse mul_done -> state=3, show_result=1.
- In BUSY, enter press then mul_done -> enter ignored, op_b still 8'hFD, state=3. Then clear press -> state=0, op_a=op_b=0, show_result=0.
- Clear and enter debounced in the same cycle in GOT_A -> state=0, op_b=0, no mul_start. Separately, mul_done pulsed in IDLE -> no change.
- Assert rst_n=0 asynchronously mid-BUSY (between clock edges) -> outputs reach the reset values before the next clk edge. A mul_done after release leaves state=0.

Source files
------------

// File: rtl/operand_entry_ctrl_pkg.sv
// rtl/operand_entry_ctrl_pkg.sv - shared state encoding and board defaults for the operand entry panel
package operand_entry_ctrl_pkg;

  // Encoding is also decoded by the LED/display logic, so values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GOT_A = 2'd1,
    ST_BUSY  = 2'd2,
    ST_SHOW  = 2'd3
  } state_e;

  localparam int DEB_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/operand_entry_ctrl_if.sv
// rtl/operand_entry_ctrl_if.sv - front-panel, multiplier and display signals of the entry sequencer
interface operand_entry_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sw;
  logic             btn_enter;
  logic             btn_clear;
  logic             mul_done;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             mul_start;
  logic             show_result;
  logic [1:0]       state;

  modport master (
    output sw, btn_enter, btn_clear, mul_done,
    input  op_a, op_b, mul_start, show_result, state
  );

  modport slave (
    input  sw, btn_enter, btn_clear, mul_done,
    output op_a, op_b, mul_start, show_result, state
  );
endinterface

// File: rtl/operand_entry_ctrl_button_debounce.sv
// rtl/operand_entry_ctrl_button_debounce.sv - per-button debouncer with a one-cycle press pulse
module button_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          press_q;

  // Counter only runs while raw disagrees; it clears at the toggle so it never wraps.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (raw != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/operand_entry_ctrl.sv
// rtl/operand_entry_ctrl.sv - operand capture sequencer driving the signed multiplier and display
module operand_entry_ctrl
  import operand_entry_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  operand_entry_ctrl_if.slave bus
);
  logic enter_press, clear_press;
  logic enter_level_unused, clear_level_unused;

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.btn_enter),
    .level (enter_level_unused),
    .press (enter_press)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.btn_clear),
    .level (clear_level_unused),
    .press (clear_press)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             mul_start_q, mul_start_d;
  logic             show_q, show_d;

  // Clear is checked first so it overrides a coincident enter or mul_done.
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    mul_start_d = 1'b0;
    if (clear_press) begin
      state_d = ST_IDLE;
      op_a_d  = '0;
      op_b_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (enter_press) begin
          op_a_d  = bus.sw;
          state_d = ST_GOT_A;
        end
        ST_GOT_A: if (enter_press) begin
          op_b_d      = bus.sw;
          mul_start_d = 1'b1;
          state_d     = ST_BUSY;
        end
        ST_BUSY: if (bus.mul_done) begin
          state_d = ST_SHOW;
        end
        ST_SHOW: if (enter_press) begin
          op_a_d  = bus.sw;
          op_b_d  = '0;
          state_d = ST_GOT_A;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    show_d = (state_d == ST_SHOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      mul_start_q <= 1'b0;
      show_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      mul_start_q <= mul_start_d;
      show_q      <= show_d;
    end
  end

  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.mul_start   = mul_start_q;
  assign bus.show_result = show_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_operand_entry_ctrl.sv
// tb/tb_operand_entry_ctrl.sv - scoreboard bench for the operand entry sequencer
module tb_operand_entry_ctrl;
  import operand_entry_ctrl_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  operand_entry_ctrl_if #(.WIDTH(WIDTH)) bus ();

  operand_entry_ctrl #(.WIDTH(WIDTH), .DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [1:0]       st;
    logic             show;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               ms;
  } exp_t;

  exp_t sb[$];

  int ms_count   = 0;
  int ms_run     = 0;
  int ms_run_max = 0;

  always @(negedge clk) begin
    if (bus.mul_start === 1'b1) begin
      ms_count++;
      ms_run++;
      if (ms_run > ms_run_max) ms_run_max = ms_run;
    end else begin
      ms_run = 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [1:0] st, input logic sh,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int ms);
    exp_t e;
    e.st = st; e.show = sh; e.a = a; e.b = b; e.ms = ms;
    sb.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val({tag, ".state"}, 32'(bus.state), 32'(e.st));
      check_val({tag, ".show"},  32'(bus.show_result), 32'(e.show));
      check_val({tag, ".op_a"},  32'(bus.op_a), 32'(e.a));
      check_val({tag, ".op_b"},  32'(bus.op_b), 32'(e.b));
      check_val({tag, ".starts"}, 32'(ms_count), 32'(e.ms));
    end
  endtask

  // Hold long enough for a press, then release long enough to debounce back low.
  task automatic press(input logic en, input logic cl, input logic [WIDTH-1:0] swv);
    bus.sw        = swv;
    bus.btn_enter = en;
    bus.btn_clear = cl;
    cyc(7);
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    bus.sw        = WIDTH'($urandom);
    cyc(6);
  endtask

  task automatic pulse_done();
    bus.mul_done = 1'b1;
    cyc(1);
    bus.mul_done = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.sw        = '0;
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    bus.mul_done  = 1'b0;
    cyc(3);
    check_val("reset.mul_start", 32'(bus.mul_start), 32'd0);
    expect_out(ST_IDLE, 1'b0, 8'h00, 8'h00, 0);
    check_sb("reset");
    rst_n = 1'b1;
    cyc(2);

    // Held enter: press lands DEB+1 edges after the rise, and only once.
    bus.sw        = 8'hF6;
    bus.btn_enter = 1'b1;
    cyc(DEB);
    check_val("latency.early", 32'(bus.state), 32'(ST_IDLE));
    cyc(1);
    check_val("latency.early2", 32'(bus.state), 32'(ST_IDLE));
    cyc(1);
    check_val("latency.capture", 32'(bus.state), 32'(ST_GOT_A));
    cyc(4);
    bus.btn_enter = 1'b0;
    bus.sw        = 8'h11;
    cyc(6);
    expect_out(ST_GOT_A, 1'b0, 8'hF6, 8'h00, 0);
    check_sb("held");

    press(1'b0, 1'b1, 8'h00);
    expect_out(ST_IDLE, 1'b0, 8'h00, 8'h00, 0);
    check_sb("clear1");

    bus.sw        = 8'h5A;
    bus.btn_enter = 1'b1;
    cyc(DEB - 1);
    bus.btn_enter = 1'b0;
    cyc(8);
    expect_out(ST_IDLE, 1'b0, 8'h00, 8'h00, 0);
    check_sb("glitch");

    press(1'b1, 1'b0, 8'h05);
    press(1'b1, 1'b0, 8'hFD);
    expect_out(ST_BUSY, 1'b0, 8'h05, 8'hFD, 1);
    check_sb("run.busy");
    pulse_done();
    expect_out(ST_SHOW, 1'b1, 8'h05, 8'hFD, 1);
    check_sb("run.show");

    press(1'b1, 1'b0, 8'h7E);
    expect_out(ST_GOT_A, 1'b0, 8'h7E, 8'h00, 1);
    check_sb("reenter");
    press(1'b0, 1'b1, 8'h00);
    expect_out(ST_IDLE, 1'b0, 8'h00, 8'h00, 1);
    check_sb("clear2");

    press(1'b1, 1'b0, 8'h05);
    press(1'b1, 1'b0, 8'hFD);
    press(1'b1, 1'b0, 8'h33);
    expect_out(ST_BUSY, 1'b0, 8'h05, 8'hFD, 2);
    check_sb("busy.ignore");
    pulse_done();
    pulse_done();
    expect_out(ST_SHOW, 1'b1, 8'h05, 8'hFD, 2);
    check_sb("busy.done");
    press(1'b0, 1'b1, 8'h00);
    expect_out(ST_IDLE, 1'b0, 8'h00, 8'h00, 2);
    check_sb("clear3");

    press(1'b1, 1'b0, 8'h44);
    press(1'b1, 1'b1, 8'h55);
    expect_out(ST_IDLE, 1'b0, 8'h00, 8'h00, 2);
    check_sb("clear_vs_enter");

    pulse_done();
    expect_out(ST_IDLE, 1'b0, 8'h00, 8'h00, 2);
    check_sb("done_idle");

    // Clear press and mul_done land on the same edge while BUSY.
    press(1'b1, 1'b0, 8'h02);
    press(1'b1, 1'b0, 8'h03);
    bus.btn_clear = 1'b1;
    cyc(DEB + 1);
    bus.mul_done = 1'b1;
    cyc(1);
    bus.mul_done = 1'b0;
    cyc(2);
    bus.btn_clear = 1'b0;
    cyc(6);
    expect_out(ST_IDLE, 1'b0, 8'h00, 8'h00, 3);
    check_sb("clear_vs_done");

    press(1'b1, 1'b0, 8'h81);
    press(1'b1, 1'b0, 8'h7F);
    expect_out(ST_BUSY, 1'b0, 8'h81, 8'h7F, 4);
    check_sb("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async.state", 32'(bus.state), 32'(ST_IDLE));
    check_val("async.op_a",  32'(bus.op_a), 32'd0);
    check_val("async.op_b",  32'(bus.op_b), 32'd0);
    check_val("async.show",  32'(bus.show_result), 32'd0);
    check_val("async.start", 32'(bus.mul_start), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    pulse_done();
    expect_out(ST_IDLE, 1'b0, 8'h00, 8'h00, 4);
    check_sb("post_reset");

    check_val("start.width", 32'(ms_run_max), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
